// File: rtl/div_recon.sv
// Reconstruction multiplier-accumulator: loads N, Q, R serially and rebuilds
// Dividend = Q*N + R by repeated addition, flagging operand consistency.
module div_recon (
  input  logic        clk,
  input  logic        clear_n,
  input  logic        start,
  input  logic [7:0]  data_input,
  output logic [15:0] Dividend,
  output logic        consistent,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_N,
    S_LD_Q,
    S_LD_R,
    S_ACC,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  n_q, n_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  r_q, r_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] dividend_q, dividend_d;
  logic        consistent_q, consistent_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // NOTE: every _d gets its hold value first so no path through the case
  // statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    cnt_d        = cnt_q;
    r_d          = r_q;
    acc_d        = acc_q;
    dividend_d   = dividend_q;
    consistent_d = consistent_q;

    case (state_q)
      S_IDLE: if (start) state_d = S_LD_N;
      S_LD_N: begin
        n_d     = data_input;
        state_d = S_LD_Q;
      end
      S_LD_Q: begin
        cnt_d   = data_input;
        state_d = S_LD_R;
      end
      S_LD_R: begin
        acc_d   = {8'h00, data_input};
        r_d     = data_input;
        state_d = S_ACC;
      end
      S_ACC: begin
        if (cnt_q != 8'd0) begin
          acc_d = acc_q + {8'h00, n_q};
          cnt_d = cnt_q - 8'd1;
        end else begin
          dividend_d   = acc_q;
          consistent_d = (n_q != 8'd0) && (r_q < n_q);
          state_d      = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status flags are decoded from the next state so they can be registered
    // and still line up with the state they describe.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from the values present before the edge.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q      <= S_IDLE;
      n_q          <= 8'd0;
      cnt_q        <= 8'd0;
      r_q          <= 8'd0;
      acc_q        <= 16'd0;
      dividend_q   <= 16'd0;
      consistent_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      cnt_q        <= cnt_d;
      r_q          <= r_d;
      acc_q        <= acc_d;
      dividend_q   <= dividend_d;
      consistent_q <= consistent_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign Dividend   = dividend_q;
  assign consistent = consistent_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
